// File: rtl/divisor_nb_ui_pkg.sv
// Shared definitions for the button-driven divider front panel.
// Holds the stage codes shown on the stage LEDs and the state width.
package divisor_nb_ui_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_ENTER_NUM = 3'd0,
        ST_ENTER_DEN = 3'd1,
        ST_CALC      = 3'd2,
        ST_SHOW_Q    = 3'd3,
        ST_SHOW_R    = 3'd4
    } state_t;

    // Buttons arrive as pad levels; a press is the rising edge of the internal level.
    function automatic logic press_edge(input logic level_now, input logic level_prev);
        return level_now & ~level_prev;
    endfunction

endpackage

// File: rtl/divisor_nb_ui_serie.sv
// Serial restoring divider: one quotient bit per clock, MSB first.
// A zero divisor finishes after one cycle with q = all ones and r = num.
module divisor_serie #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic             busy_q, busy_d;
    logic             zero_q, zero_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;

    logic [WIDTH+1:0] trial;
    logic             borrow;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    // quo_q starts as the numerator and shifts its bits into the remainder while
    // the quotient bits shift in from the bottom.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]} - {2'b00, den_q};
        borrow   = trial[WIDTH+1];
        rem_next = borrow ? {rem_q[WIDTH-1:0], quo_q[WIDTH-1]} : trial[WIDTH:0];
        quo_next = {quo_q[WIDTH-2:0], ~borrow};
        done     = busy_q && (zero_q || (cnt_q == LAST_CNT));

        busy_d = busy_q;
        zero_d = zero_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        q_d    = q_q;
        r_d    = r_q;

        if (start && !busy_q) begin
            busy_d = 1'b1;
            zero_d = (den == '0);
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = num;
            den_d  = den;
        end else if (busy_q) begin
            if (zero_q) begin
                busy_d = 1'b0;
                q_d    = '1;
                r_d    = quo_q;
            end else begin
                rem_d = rem_next;
                quo_d = quo_next;
                cnt_d = cnt_q + CNT_ONE;
                if (done) begin
                    busy_d = 1'b0;
                    q_d    = quo_next;
                    r_d    = rem_next[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            zero_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
        end else begin
            busy_q <= busy_d;
            zero_q <= zero_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            den_q  <= den_d;
            q_q    <= q_d;
            r_q    <= r_d;
        end
    end

    assign busy     = busy_q;
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = zero_q;

endmodule

// File: rtl/divisor_nb_ui.sv
// Divider front panel: operands entered with up/down/ok, result shown on leds.
// Holds the stage FSM, button edge detectors, operand counters and the leds mux.
module divisor_nb_ui
    import divisor_nb_ui_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit BTN_ACT_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               ok,
    output logic [WIDTH-1:0]   leds,
    output logic [STATE_W-1:0] stage,
    output logic               busy,
    output logic               div_zero
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             up_i, down_i, ok_i;
    logic             up_p, down_p, ok_p;
    logic [2:0]       btn_q, btn_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             dz_q, dz_d;
    logic             start;

    logic             dv_busy, dv_done, dv_div_zero;
    logic [WIDTH-1:0] dv_q, dv_r;

    function automatic logic [WIDTH-1:0] step_operand(input logic [WIDTH-1:0] v,
                                                      input logic inc,
                                                      input logic dec);
        if (inc && !dec) begin
            return v + ONE;
        end else if (dec && !inc) begin
            return v - ONE;
        end
        return v;
    endfunction

    assign up_i   = BTN_ACT_LOW ? ~up   : up;
    assign down_i = BTN_ACT_LOW ? ~down : down;
    assign ok_i   = BTN_ACT_LOW ? ~ok   : ok;

    assign up_p   = press_edge(up_i,   btn_q[2]);
    assign down_p = press_edge(down_i, btn_q[1]);
    assign ok_p   = press_edge(ok_i,   btn_q[0]);
    assign btn_d  = {up_i, down_i, ok_i};

    assign start  = (state_q == ST_ENTER_DEN) && ok_p;

    divisor_serie #(.WIDTH(WIDTH)) u_div (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .num     (num_q),
        .den     (den_q),
        .busy    (dv_busy),
        .done    (dv_done),
        .q       (dv_q),
        .r       (dv_r),
        .div_zero(dv_div_zero)
    );

    // ok always wins over up/down on the same edge; unused codes behave as ENTER_NUM.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        den_d   = den_q;
        dz_d    = dz_q;
        leds    = num_q;

        case (state_q)
            ST_ENTER_DEN: begin
                leds = den_q;
                if (ok_p) begin
                    state_d = ST_CALC;
                end else begin
                    den_d = step_operand(den_q, up_p, down_p);
                end
            end
            ST_CALC: begin
                leds = '0;
                if (dv_done) begin
                    state_d = ST_SHOW_Q;
                    dz_d    = dv_div_zero;
                end
            end
            ST_SHOW_Q: begin
                leds = dv_q;
                if (ok_p) begin
                    state_d = ST_SHOW_R;
                end
            end
            ST_SHOW_R: begin
                leds = dv_r;
                if (ok_p) begin
                    state_d = ST_ENTER_NUM;
                    dz_d    = 1'b0;
                end
            end
            default: begin
                leds = num_q;
                if (ok_p) begin
                    state_d = ST_ENTER_DEN;
                end else begin
                    num_d = step_operand(num_q, up_p, down_p);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q   <= '0;
            state_q <= ST_ENTER_NUM;
            num_q   <= '0;
            den_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            btn_q   <= btn_d;
            state_q <= state_d;
            num_q   <= num_d;
            den_q   <= den_d;
            dz_q    <= dz_d;
        end
    end

    assign stage    = state_q;
    assign busy     = dv_busy;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_divisor_nb_ui.sv
// Self-checking bench for the divider front panel: an 8-bit active-low panel for
// the directed scenarios and a 4-bit active-high panel for the full operand sweep.
module tb_divisor_nb_ui;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       up8 = 1'b0, down8 = 1'b0, ok8 = 1'b0;
    logic [7:0] leds8;
    logic [2:0] stage8;
    logic       busy8, dz8;

    logic       up4 = 1'b0, down4 = 1'b0, ok4 = 1'b0;
    logic [3:0] leds4;
    logic [2:0] stage4;
    logic       busy4, dz4;

    int total = 0;
    int bad   = 0;

    divisor_nb_ui #(.WIDTH(8), .BTN_ACT_LOW(1'b1)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .up      (~up8),
        .down    (~down8),
        .ok      (~ok8),
        .leds    (leds8),
        .stage   (stage8),
        .busy    (busy8),
        .div_zero(dz8)
    );

    divisor_nb_ui #(.WIDTH(4), .BTN_ACT_LOW(1'b0)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .up      (up4),
        .down    (down4),
        .ok      (ok4),
        .leds    (leds4),
        .stage   (stage4),
        .busy    (busy4),
        .div_zero(dz4)
    );

    // Every comparison funnels through here so the counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One press on the 8-bit panel: asserted for one cycle, then released for one.
    task automatic applyStimulus(input logic u, input logic d, input logic o);
        @(negedge clk);
        up8 = u; down8 = d; ok8 = o;
        @(negedge clk);
        up8 = 1'b0; down8 = 1'b0; ok8 = 1'b0;
    endtask

    task automatic applyStimulus4(input logic u, input logic d, input logic o);
        @(negedge clk);
        up4 = u; down4 = d; ok4 = o;
        @(negedge clk);
        up4 = 1'b0; down4 = 1'b0; ok4 = 1'b0;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Counts busy cycles of the 8-bit panel, bounded so a stuck divider cannot hang.
    task automatic countBusy8(output int n);
        n = 0;
        while (busy8 && n < 50) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int cur_n, cur_d;
        int wait_cnt;
        int exp_q, exp_r;
        logic [3:0] got_q, got_r;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset stage", stage8, 0);
        checkOutput("reset leds", leds8, 0);
        checkOutput("reset busy", busy8, 0);
        checkOutput("reset div_zero", dz8, 0);
        rst = 1'b0;

        // 1: 100 / 7
        $display("[TB] scenario 1: 100 / 7");
        repeat (100) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1 num", leds8, 100);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1 stage den", stage8, 1);
        checkOutput("t1 den start", leds8, 0);
        repeat (7) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1 den", leds8, 7);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1 calc stage", stage8, 2);
        checkOutput("t1 calc leds", leds8, 0);
        countBusy8(n);
        checkOutput("t1 busy cycles", n, 8);
        checkOutput("t1 show_q stage", stage8, 3);
        checkOutput("t1 quotient", leds8, 14);
        checkOutput("t1 div_zero", dz8, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1 show_r stage", stage8, 4);
        checkOutput("t1 remainder", leds8, 2);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t1 back stage", stage8, 0);
        checkOutput("t1 retained num", leds8, 100);

        // 2: 9 / 0
        $display("[TB] scenario 2: divide by zero");
        doReset();
        repeat (9) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        countBusy8(n);
        checkOutput("t2 busy cycles", n, 1);
        checkOutput("t2 show_q stage", stage8, 3);
        checkOutput("t2 div_zero set", dz8, 1);
        checkOutput("t2 quotient", leds8, 255);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t2 remainder", leds8, 9);
        checkOutput("t2 div_zero held", dz8, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t2 back stage", stage8, 0);
        checkOutput("t2 div_zero cleared", dz8, 0);
        checkOutput("t2 retained num", leds8, 9);

        // 3: wrap and held button
        $display("[TB] scenario 3: wrap and hold");
        doReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3 wrap down", leds8, 255);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3 wrap up", leds8, 0);
        @(negedge clk);
        up8 = 1'b1;
        repeat (20) @(negedge clk);
        up8 = 1'b0;
        @(negedge clk);
        checkOutput("t3 held up", leds8, 1);

        // 4: simultaneous buttons
        $display("[TB] scenario 4: simultaneous presses");
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4 up+down num", leds8, 1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("t4 ok+down stage", stage8, 1);
        checkOutput("t4 ok+down den", leds8, 0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("t4 up+down den", leds8, 0);
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4 den", leds8, 3);
        applyStimulus(1'b0, 1'b0, 1'b1);
        countBusy8(n);
        checkOutput("t4 quotient", leds8, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4 remainder", leds8, 1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t4 num unchanged", leds8, 1);

        // 5: reset in the middle of a division
        $display("[TB] scenario 5: reset mid-division");
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("t5 calc busy", busy8, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5 async stage", stage8, 0);
        checkOutput("t5 async busy", busy8, 0);
        checkOutput("t5 async leds", leds8, 0);
        @(negedge clk);
        rst = 1'b0;

        // 6: full 4-bit sweep with retention between passes
        $display("[TB] scenario 6: 4-bit sweep");
        cur_n = 0;
        cur_d = 0;
        for (int nn = 0; nn < 16; nn++) begin
            for (int dd = 0; dd < 16; dd++) begin
                while (cur_n != nn) begin
                    applyStimulus4(1'b1, 1'b0, 1'b0);
                    cur_n = (cur_n + 1) % 16;
                end
                applyStimulus4(1'b0, 1'b0, 1'b1);
                while (cur_d != dd) begin
                    applyStimulus4(1'b1, 1'b0, 1'b0);
                    cur_d = (cur_d + 1) % 16;
                end
                applyStimulus4(1'b0, 1'b0, 1'b1);
                wait_cnt = 0;
                while (stage4 != 3'd3 && wait_cnt < 40) begin
                    wait_cnt++;
                    @(negedge clk);
                end
                if (wait_cnt >= 40) checkOutput("t6 calc timeout stage", stage4, 3);
                if (dd == 0) begin
                    exp_q = 15;
                    exp_r = nn;
                end else begin
                    exp_q = nn / dd;
                    exp_r = nn % dd;
                end
                got_q = leds4;
                checkOutput($sformatf("t6 q %0d/%0d", nn, dd), got_q, exp_q);
                checkOutput($sformatf("t6 dz %0d/%0d", nn, dd), dz4, (dd == 0) ? 1 : 0);
                applyStimulus4(1'b0, 1'b0, 1'b1);
                got_r = leds4;
                checkOutput($sformatf("t6 r %0d/%0d", nn, dd), got_r, exp_r);
                if (dd != 0) begin
                    checkOutput($sformatf("t6 invariant %0d/%0d", nn, dd),
                                got_q * dd + got_r, nn);
                end
                applyStimulus4(1'b0, 1'b0, 1'b1);
                checkOutput($sformatf("t6 retained %0d/%0d", nn, dd), leds4, nn);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
